// File: rtl/store_write_buffer.sv
`default_nettype none
// ============================================================================
// store_write_buffer : FIFO of lane-aligned stores drained to data memory
// Revision: 1.0
// ============================================================================
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     StValid,
  output logic                     StReady,
  input  logic [AW-1:0]            StAddr,
  input  logic [31:0]              StData,
  input  logic [1:0]               StSize,
  output logic                     StErr,
  output logic                     MemWrReq,
  output logic [AW-1:0]            MemAddr,
  output logic [31:0]              MemWData,
  output logic [3:0]               MemBE,
  input  logic                     MemAck,
  output logic                     Empty,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          st_err_q, st_err_d;
  logic          mem_wr_req_q, mem_wr_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;

  logic [AW-1:0] addr_mem_q [DEPTH];
  logic [AW-1:0] addr_mem_d [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic [31:0]   data_mem_d [DEPTH];
  logic [3:0]    be_mem_q   [DEPTH];
  logic [3:0]    be_mem_d   [DEPTH];

  logic          aligned;
  logic [31:0]   fmt_data;
  logic [3:0]    fmt_be;
  logic          push;
  logic          load_head;
  logic          pop_head;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
  assign StReady  = !RST && (count_q != CW'(DEPTH));
  assign StErr    = st_err_q;
  assign MemWrReq = mem_wr_req_q;
  assign MemAddr  = mem_addr_q;
  assign MemWData = mem_wdata_q;
  assign MemBE    = mem_be_q;
  assign Count    = count_q;
  assign Empty    = (count_q == '0) && !mem_wr_req_q;

  // Little-endian lane placement; unused lanes stay zero.
  always_comb begin
    aligned  = 1'b0;
    fmt_data = '0;
    fmt_be   = '0;
    case (StSize)
      2'b00: begin
        aligned  = 1'b1;
        fmt_be   = 4'b0001 << StAddr[1:0];
        fmt_data = {24'h0, StData[7:0]} << {StAddr[1:0], 3'b000};
      end
      2'b01: begin
        aligned  = !StAddr[0];
        fmt_be   = StAddr[1] ? 4'b1100 : 4'b0011;
        fmt_data = StAddr[1] ? {StData[15:0], 16'h0} : {16'h0, StData[15:0]};
      end
      2'b10: begin
        aligned  = (StAddr[1:0] == 2'b00);
        fmt_be   = 4'b1111;
        fmt_data = StData;
      end
      default: ;
    endcase
  end

  always_comb begin
    push       = StValid && StReady && aligned;
    st_err_d   = StValid && StReady && !aligned;
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    be_mem_d   = be_mem_q;
    if (push) begin
      addr_mem_d[wr_ptr_q] = {StAddr[AW-1:2], 2'b00};
      data_mem_d[wr_ptr_q] = fmt_data;
      be_mem_d[wr_ptr_q]   = fmt_be;
    end
    wr_ptr_d = push     ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop_head ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop_head})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WAIT;
      S_WAIT:  if (MemAck)        state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The head entry stays in the FIFO until the ack, so it remains counted while in flight.
  always_comb begin
    load_head    = 1'b0;
    pop_head     = 1'b0;
    case (state_q)
      S_IDLE:  load_head = (count_q != '0);
      S_WAIT:  pop_head  = MemAck;
      default: ;
    endcase
    mem_wr_req_d = mem_wr_req_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    if (load_head) begin
      mem_wr_req_d = 1'b1;
      mem_addr_d   = addr_mem_q[rd_ptr_q];
      mem_wdata_d  = data_mem_q[rd_ptr_q];
      mem_be_d     = be_mem_q[rd_ptr_q];
    end else if (pop_head) begin
      mem_wr_req_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      st_err_q     <= 1'b0;
      mem_wr_req_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      addr_mem_q   <= '{default: '0};
      data_mem_q   <= '{default: '0};
      be_mem_q     <= '{default: '0};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      st_err_q     <= st_err_d;
      mem_wr_req_q <= mem_wr_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      addr_mem_q   <= addr_mem_d;
      data_mem_q   <= data_mem_d;
      be_mem_q     <= be_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_write_buffer.sv
`default_nettype none
// ============================================================================
// tb_store_write_buffer : directed stimulus with a queue-based write scoreboard
// Revision: 1.0
// ============================================================================
module tb_store_write_buffer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        StValid;
  logic        StReady;
  logic [31:0] StAddr;
  logic [31:0] StData;
  logic [1:0]  StSize;
  logic        StErr;
  logic        MemWrReq;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBE;
  logic        MemAck;
  logic        Empty;
  logic [2:0]  Count;

  store_write_buffer #(.DEPTH(4), .AW(32)) dut (
    .CLK(CLK), .RST(RST),
    .StValid(StValid), .StReady(StReady), .StAddr(StAddr), .StData(StData),
    .StSize(StSize), .StErr(StErr),
    .MemWrReq(MemWrReq), .MemAddr(MemAddr), .MemWData(MemWData), .MemBE(MemBE),
    .MemAck(MemAck), .Empty(Empty), .Count(Count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   ncmp  = 0;
  int   nfail = 0;

  // 0: ack low, 1: ack tied high, 2: ack two cycles into a request
  int   ack_mode = 0;
  int   req_cycles = 0;

  always @(posedge CLK) begin
    if (MemWrReq) req_cycles <= req_cycles + 1;
    else          req_cycles <= 0;
  end

  always_comb begin
    MemAck = 1'b0;
    case (ack_mode)
      1:       MemAck = 1'b1;
      2:       MemAck = MemWrReq && (req_cycles >= 2);
      default: MemAck = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: each write completing at the coming edge is checked against the queue head.
  always @(negedge CLK) begin
    if (RST === 1'b0 && MemWrReq && MemAck) begin
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_write: got addr %h data %h be %b expected no write",
                 MemAddr, MemWData, MemBE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", MemAddr, e.a);
        chk("wr_data", MemWData, e.d);
        chk("wr_be", {28'h0, MemBE}, {28'h0, e.be});
      end
    end
    if (RST === 1'b0) chk("count_le_depth", {31'h0, (Count > 3'd4)}, 32'h0);
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                       input bit ok, input logic [31:0] ea, input logic [31:0] ed,
                       input logic [3:0] ebe);
    int guard;
    StValid = 1'b1;
    StAddr  = a;
    StData  = d;
    StSize  = sz;
    guard   = 0;
    #1;
    while (!StReady && guard < 50) begin
      tick;
      guard++;
    end
    if (!StReady) begin
      ncmp++;
      nfail++;
      $display("FAIL store_timeout: got StReady 0 expected 1 for addr %h", a);
    end else if (ok) begin
      sb.push_back('{a: ea, d: ed, be: ebe});
    end
    tick;
    StValid = 1'b0;
  endtask

  task automatic wait_drain;
    int guard;
    guard = 0;
    while ((sb.size() != 0 || !Empty) && guard < 60) begin
      tick;
      guard++;
    end
    chk("drain_done", {31'h0, (sb.size() == 0 && Empty)}, 32'h1);
  endtask

  initial begin
    RST = 1'b1; StValid = 1'b0; StAddr = '0; StData = '0; StSize = '0;
    tick; tick;
    chk("rst_stready", {31'h0, StReady}, 32'h0);
    chk("rst_count", {29'h0, Count}, 32'h0);
    chk("rst_empty", {31'h0, Empty}, 32'h1);
    chk("rst_sterr", {31'h0, StErr}, 32'h0);
    chk("rst_req", {31'h0, MemWrReq}, 32'h0);
    chk("rst_addr", MemAddr, 32'h0);
    chk("rst_wdata", MemWData, 32'h0);
    chk("rst_be", {28'h0, MemBE}, 32'h0);
    RST = 1'b0;
    tick;

    // Word store, delayed ack
    ack_mode = 2;
    store(32'h0000_1004, 32'hDEADBEEF, 2'b10, 1'b1, 32'h1004, 32'hDEADBEEF, 4'b1111);
    chk("t1_count_after_push", {29'h0, Count}, 32'h1);
    chk("t1_req_not_yet", {31'h0, MemWrReq}, 32'h0);
    tick;
    chk("t1_req_rise", {31'h0, MemWrReq}, 32'h1);
    chk("t1_addr", MemAddr, 32'h1004);
    chk("t1_wdata", MemWData, 32'hDEADBEEF);
    tick;
    chk("t1_empty_busy", {31'h0, Empty}, 32'h0);
    tick;
    chk("t1_empty_busy2", {31'h0, Empty}, 32'h0);
    tick;
    chk("t1_empty_after_ack", {31'h0, Empty}, 32'h1);
    chk("t1_req_after_ack", {31'h0, MemWrReq}, 32'h0);

    // Byte and halfword lanes, ack tied high
    ack_mode = 1;
    store(32'h2001, 32'h0000_00AA, 2'b00, 1'b1, 32'h2000, 32'h0000AA00, 4'b0010);
    store(32'h2003, 32'h0000_00AA, 2'b00, 1'b1, 32'h2000, 32'hAA000000, 4'b1000);
    store(32'h2000, 32'h1234_56C3, 2'b00, 1'b1, 32'h2000, 32'h000000C3, 4'b0001);
    store(32'h3002, 32'h0000_1234, 2'b01, 1'b1, 32'h3000, 32'h12340000, 4'b1100);
    store(32'h3000, 32'hFFFF_5678, 2'b01, 1'b1, 32'h3000, 32'h00005678, 4'b0011);
    wait_drain;

    // Misaligned / illegal stores are dropped with a one-cycle error pulse
    store(32'h3001, 32'h0000_1234, 2'b01, 1'b0, '0, '0, '0);
    chk("t3_sterr_hw", {31'h0, StErr}, 32'h1);
    chk("t3_count_hw", {29'h0, Count}, 32'h0);
    tick;
    chk("t3_sterr_clear", {31'h0, StErr}, 32'h0);
    chk("t3_no_req", {31'h0, MemWrReq}, 32'h0);
    store(32'h4002, 32'h1111_2222, 2'b10, 1'b0, '0, '0, '0);
    chk("t3_sterr_word", {31'h0, StErr}, 32'h1);
    store(32'h4000, 32'h1111_2222, 2'b11, 1'b0, '0, '0, '0);
    chk("t3_sterr_illegal", {31'h0, StErr}, 32'h1);
    chk("t3_count_illegal", {29'h0, Count}, 32'h0);
    tick; tick;
    chk("t3_empty", {31'h0, Empty}, 32'h1);

    // Fill with ack low, hold off the fifth, then release
    ack_mode = 0;
    store(32'h5000, 32'h1111_1111, 2'b10, 1'b1, 32'h5000, 32'h11111111, 4'b1111);
    store(32'h5004, 32'h2222_2222, 2'b10, 1'b1, 32'h5004, 32'h22222222, 4'b1111);
    store(32'h5008, 32'h3333_3333, 2'b10, 1'b1, 32'h5008, 32'h33333333, 4'b1111);
    store(32'h500C, 32'h4444_4444, 2'b10, 1'b1, 32'h500C, 32'h44444444, 4'b1111);
    chk("t4_full_ready", {31'h0, StReady}, 32'h0);
    chk("t4_full_count", {29'h0, Count}, 32'h4);
    StValid = 1'b1; StAddr = 32'h5011; StData = 32'h55; StSize = 2'b00;
    sb.push_back('{a: 32'h5010, d: 32'h00005500, be: 4'b0010});
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t4_held_count", {29'h0, Count}, 32'h4);
      chk("t4_held_ready", {31'h0, StReady}, 32'h0);
    end
    ack_mode = 1;
    tick;
    chk("t5_pop_no_push", {29'h0, Count}, 32'h3);
    chk("t5_ready_rise", {31'h0, StReady}, 32'h1);
    tick;
    chk("t5_push_next", {29'h0, Count}, 32'h4);
    StValid = 1'b0;
    wait_drain;

    // Reset while a write is in flight
    ack_mode = 0;
    store(32'h7000, 32'hAAAA_0001, 2'b10, 1'b1, 32'h7000, 32'hAAAA0001, 4'b1111);
    store(32'h7004, 32'hAAAA_0002, 2'b10, 1'b1, 32'h7004, 32'hAAAA0002, 4'b1111);
    store(32'h7008, 32'hAAAA_0003, 2'b10, 1'b1, 32'h7008, 32'hAAAA0003, 4'b1111);
    tick;
    chk("t6_pre_count", {29'h0, Count}, 32'h3);
    chk("t6_pre_req", {31'h0, MemWrReq}, 32'h1);
    RST = 1'b1;
    ack_mode = 1;
    #1;
    chk("t6_rst_stready", {31'h0, StReady}, 32'h0);
    tick;
    sb.delete();
    chk("t6_req", {31'h0, MemWrReq}, 32'h0);
    chk("t6_count", {29'h0, Count}, 32'h0);
    chk("t6_empty", {31'h0, Empty}, 32'h1);
    chk("t6_be", {28'h0, MemBE}, 32'h0);
    RST = 1'b0;
    ack_mode = 2;
    tick;
    store(32'h6000, 32'hCAFE_F00D, 2'b10, 1'b1, 32'h6000, 32'hCAFEF00D, 4'b1111);
    tick;
    chk("t6_new_addr", MemAddr, 32'h6000);
    chk("t6_new_data", MemWData, 32'hCAFEF00D);
    wait_drain;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
